// File: rtl/dsp_mac_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiply-accumulate datapath
// among NUM_REQ requesters; results return tagged to the issuer PIPE+1 cycles after accept.
module dsp_mac_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 16,
    parameter int PIPE    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*2*WIDTH-1:0] req_c,
    input  logic [NUM_REQ-1:0]         req_acc,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       busy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = 2 * WIDTH;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [IDW-1:0]     rr_ptr_r;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDW-1:0]     gnt_id_s;
    logic               found_s;
    logic               hit_s;
    logic               accept_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [PW-1:0]      sel_c_s;

    logic [WIDTH-1:0]   iss_a_r;
    logic [WIDTH-1:0]   iss_b_r;
    logic [PW-1:0]      iss_c_r;
    logic [IDW-1:0]     iss_id_r;
    logic               iss_v_r;
    logic [PW-1:0]      prod_s;

    logic [PW-1:0]      fin_p_s;
    logic [PW-1:0]      fin_c_s;
    logic [IDW-1:0]     fin_id_s;
    logic               fin_v_s;
    logic               mid_busy_s;

    function automatic int rr_pos(input logic [IDW-1:0] ptr, input int k);
        int sum;
        sum = int'(ptr) + k;
        return (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping; muxes its operands
    always_comb begin
        gnt_s    = '0;
        gnt_id_s = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        sel_c_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s    = ~found_s & req_valid[i] & (rr_pos(rr_ptr_r, k) == i);
                gnt_s[i] = gnt_s[i] | hit_s;
                gnt_id_s = hit_s ? IDW'(i) : gnt_id_s;
                sel_a_s  = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{hit_s}});
                sel_b_s  = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{hit_s}});
                sel_c_s  = sel_c_s | (req_c[i*PW +: PW] & {PW{hit_s & req_acc[i]}});
                found_s  = found_s | hit_s;
            end
        end
    end

    assign req_ready = gnt_s & {NUM_REQ{~rst}};
    assign accept_s  = found_s & ~rst;
    assign prod_s    = PW'(iss_a_r) * PW'(iss_b_r);

    // Issue stage and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
            iss_a_r  <= '0;
            iss_b_r  <= '0;
            iss_c_r  <= '0;
            iss_id_r <= '0;
            iss_v_r  <= 1'b0;
        end else begin
            iss_v_r <= accept_s;
            if (accept_s) begin
                rr_ptr_r <= (gnt_id_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_s + IDW'(1);
                iss_a_r  <= sel_a_s;
                iss_b_r  <= sel_b_s;
                iss_c_r  <= sel_c_s;
                iss_id_r <= gnt_id_s;
            end
        end
    end

    generate
        if (PIPE > 1) begin : g_mid
            logic [PW-1:0]  p_r  [PIPE-1];
            logic [PW-1:0]  c_r  [PIPE-1];
            logic [IDW-1:0] id_r [PIPE-1];
            logic [PIPE-2:0] v_r;

            // Product, addend and tag ride the intermediate multiplier stages
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < PIPE - 1; s++) begin
                        p_r[s]  <= '0;
                        c_r[s]  <= '0;
                        id_r[s] <= '0;
                    end
                    v_r <= '0;
                end else begin
                    p_r[0]  <= prod_s;
                    c_r[0]  <= iss_c_r;
                    id_r[0] <= iss_id_r;
                    v_r[0]  <= iss_v_r;
                    for (int s = 1; s < PIPE - 1; s++) begin
                        p_r[s]  <= p_r[s-1];
                        c_r[s]  <= c_r[s-1];
                        id_r[s] <= id_r[s-1];
                        v_r[s]  <= v_r[s-1];
                    end
                end
            end

            assign fin_p_s    = p_r[PIPE-2];
            assign fin_c_s    = c_r[PIPE-2];
            assign fin_id_s   = id_r[PIPE-2];
            assign fin_v_s    = v_r[PIPE-2];
            assign mid_busy_s = |v_r;
        end else begin : g_direct
            assign fin_p_s    = prod_s;
            assign fin_c_s    = iss_c_r;
            assign fin_id_s   = iss_id_r;
            assign fin_v_s    = iss_v_r;
            assign mid_busy_s = 1'b0;
        end
    endgenerate

    // Final stage adds c and doubles as the response register; data holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= fin_v_s ? (ONE_HOT0 << fin_id_s) : '0;
            if (fin_v_s) begin
                rsp_data <= fin_p_s + fin_c_s;
            end
        end
    end

    assign busy = iss_v_r | mid_busy_s | (|rsp_valid);

endmodule
